// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bundle.
// Single-outstanding req/gnt with a separate rvalid response.
interface instruction_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, IF/ID register, one-deep response hold buffer.
// Redirects land after one delay slot; no wrong-path fetches.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       jump_branch,
  input  logic                       jump_target,
  input  logic                       jump_reg,
  input  logic [31:0]                jr_pc,
  instruction_fetch_if.master        imem,
  output logic [31:0]                pc_id,
  output logic [31:0]                instr_id,
  output logic                       instr_valid
);

  logic        run;
  logic        outstanding;
  logic        hold_valid;
  logic        redir_pending;
  logic [31:0] req_pc;
  logic [31:0] last_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic [31:0] redir_pc;

  logic        adv;
  logic        rv;
  logic        fire;
  logic        take;
  logic        ds_issued;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic [31:0] addr;

  assign adv       = ~(instr_valid & stall);
  // A response only counts while we are waiting for one.
  assign rv        = imem.rvalid & outstanding;
  assign pc4       = pc_id + 32'd4;
  assign br_off    = {{14{instr_id[15]}},
                      instr_id[15:0], 2'b00};
  assign take      = instr_valid & ~stall &
                     (jump_reg | jump_target | jump_branch);
  assign ds_issued = (last_pc == pc4);

  // Redirect target, jr over j over branch.
  always_comb begin
    target = pc4 + br_off;
    if (jump_reg) begin
      target = jr_pc;
    end else if (jump_target) begin
      target = {pc4[31:28], instr_id[25:0], 2'b00};
    end
  end

  // Request and address: redirect straight out once the slot is issued.
  always_comb begin
    imem.req = run & ~hold_valid &
               (~outstanding | (rv & adv));
    addr     = (take & ds_issued) ? target : req_pc;
    fire     = imem.req & imem.gnt;
  end

  assign imem.addr = addr;

  // PC sequencing and deferred redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      req_pc        <= RESET_PC;
      last_pc       <= RESET_PC - 32'd4;
      outstanding   <= 1'b0;
      redir_pending <= 1'b0;
      redir_pc      <= RESET_PC;
    end else begin
      run <= 1'b1;
      if (fire) begin
        last_pc     <= addr;
        outstanding <= 1'b1;
        if (redir_pending) begin
          req_pc        <= redir_pc;
          redir_pending <= 1'b0;
        end else if (take & ~ds_issued) begin
          req_pc <= target;
        end else begin
          req_pc <= addr + 32'd4;
        end
      end else begin
        if (rv) begin
          outstanding <= 1'b0;
        end
        if (take & ds_issued) begin
          req_pc <= target;
        end else if (take) begin
          redir_pending <= 1'b1;
          redir_pc      <= target;
        end
      end
    end
  end

  // IF/ID load priority: hold buffer, then response, then bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr_id    <= 32'h0;
      pc_id       <= RESET_PC;
      hold_valid  <= 1'b0;
      hold_instr  <= 32'h0;
      hold_pc     <= RESET_PC;
    end else if (adv) begin
      if (hold_valid) begin
        instr_valid <= 1'b1;
        instr_id    <= hold_instr;
        pc_id       <= hold_pc;
        hold_valid  <= 1'b0;
      end else if (rv) begin
        instr_valid <= 1'b1;
        instr_id    <= imem.rdata;
        pc_id       <= last_pc;
      end else begin
        instr_valid <= 1'b0;
        instr_id    <= 32'h0;
      end
    end else if (rv) begin
      hold_valid <= 1'b1;
      hold_instr <= imem.rdata;
      hold_pc    <= last_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table plus
// redirect-pending and mid-request reset sequences.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        tb_jb = 1'b0;
  logic        jump_target = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_pc = 32'h0;
  logic        jump_branch;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic auto_br = 1'b0;
  logic block14 = 1'b0;
  logic br_seen;
  logic mem_busy;
  int   mem_cnt;
  logic [31:0] mem_a;
  logic [31:0] glog[$];
  logic [31:0] ilog[$];

  instruction_fetch_if imem();

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .jr_pc       (jr_pc),
    .imem        (imem),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h1000_0004;
      32'h100: return 32'h0800_0080;
      default: return {16'h2000, a[15:0]};
    endcase
  endfunction

  assign jump_branch = tb_jb |
    (auto_br & instr_valid & (pc_id == 32'h10));
  assign imem.gnt = ~(block14 & ~br_seen &
                      (imem.addr == 32'h14));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem.rvalid <= 1'b0;
      imem.rdata  <= 32'h0;
      mem_busy    <= 1'b0;
      mem_cnt     <= 0;
      mem_a       <= 32'h0;
      br_seen     <= 1'b0;
    end else begin
      imem.rvalid <= 1'b0;
      if (instr_valid && pc_id == 32'h10) br_seen <= 1'b1;
      if (imem.req && imem.gnt) begin
        glog.push_back(imem.addr);
        if (lat == 1) begin
          imem.rvalid <= 1'b1;
          imem.rdata  <= f(imem.addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= lat - 1;
          mem_a    <= imem.addr;
        end
      end else if (mem_busy) begin
        if (mem_cnt == 1) begin
          imem.rvalid <= 1'b1;
          imem.rdata  <= f(mem_a);
          mem_busy    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && instr_valid && !stall) ilog.push_back(pc_id);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] jrpc;
    logic [1:0]  flg;
    logic [31:0] eaddr;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl,
                              input logic [31:0] jrpc,
                              input logic [1:0] flg,
                              input logic [31:0] eaddr,
                              input logic [31:0] epc);
    vec_t v;
    v.ctl = ctl; v.jrpc = jrpc; v.flg = flg;
    v.eaddr = eaddr; v.epc = epc;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    int n;
    logic [31:0] eg[7];
    logic [31:0] ei[7];
    logic [31:0] ei_exp;
    // ctl = {stall, jb, jt, jr}; flg = {req, valid}
    tbl[0]  = mk(4'b0000, 32'h0,   2'b10, 32'h00,  32'h00);
    tbl[1]  = mk(4'b0000, 32'h0,   2'b10, 32'h04,  32'h00);
    tbl[2]  = mk(4'b0000, 32'h0,   2'b11, 32'h08,  32'h00);
    tbl[3]  = mk(4'b0000, 32'h0,   2'b11, 32'h0C,  32'h04);
    tbl[4]  = mk(4'b0000, 32'h0,   2'b11, 32'h10,  32'h08);
    tbl[5]  = mk(4'b0000, 32'h0,   2'b11, 32'h14,  32'h0C);
    tbl[6]  = mk(4'b0100, 32'h0,   2'b11, 32'h24,  32'h10);
    tbl[7]  = mk(4'b0000, 32'h0,   2'b11, 32'h28,  32'h14);
    tbl[8]  = mk(4'b0000, 32'h0,   2'b11, 32'h2C,  32'h24);
    tbl[9]  = mk(4'b1000, 32'h0,   2'b01, 32'h30,  32'h28);
    tbl[10] = mk(4'b1001, 32'h100, 2'b01, 32'h30,  32'h28);
    tbl[11] = mk(4'b1000, 32'h0,   2'b01, 32'h30,  32'h28);
    tbl[12] = mk(4'b0000, 32'h0,   2'b01, 32'h30,  32'h28);
    tbl[13] = mk(4'b0000, 32'h0,   2'b11, 32'h30,  32'h2C);
    tbl[14] = mk(4'b0000, 32'h0,   2'b10, 32'h34,  32'h2C);
    tbl[15] = mk(4'b0001, 32'h100, 2'b11, 32'h100, 32'h30);
    tbl[16] = mk(4'b0000, 32'h0,   2'b11, 32'h104, 32'h34);
    tbl[17] = mk(4'b0010, 32'h0,   2'b11, 32'h200, 32'h100);
    tbl[18] = mk(4'b0000, 32'h0,   2'b11, 32'h204, 32'h104);
    tbl[19] = mk(4'b0011, 32'h300, 2'b11, 32'h300, 32'h200);
    tbl[20] = mk(4'b0000, 32'h0,   2'b11, 32'h304, 32'h204);
    tbl[21] = mk(4'b0000, 32'h0,   2'b11, 32'h308, 32'h300);

    // Reset state
    lat = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", {31'h0, imem.req}, 32'h0);
    chk("rst valid", {31'h0, instr_valid}, 32'h0);
    chk("rst instr", instr_id, 32'h0);
    chk("rst pc", pc_id, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Straight line, branch, stall, jr, j, priority at 1-cycle latency
    for (int i = 0; i < 22; i++) begin
      stall       = tbl[i].ctl[3];
      tb_jb       = tbl[i].ctl[2];
      jump_target = tbl[i].ctl[1];
      jump_reg    = tbl[i].ctl[0];
      jr_pc       = tbl[i].jrpc;
      #1;
      chk($sformatf("v%0d req", i),
          {31'h0, imem.req}, {31'h0, tbl[i].flg[1]});
      if (tbl[i].flg[1])
        chk($sformatf("v%0d addr", i), imem.addr, tbl[i].eaddr);
      chk($sformatf("v%0d valid", i),
          {31'h0, instr_valid}, {31'h0, tbl[i].flg[0]});
      chk($sformatf("v%0d pc", i), pc_id, tbl[i].epc);
      ei_exp = tbl[i].flg[0] ? f(tbl[i].epc) : 32'h0;
      chk($sformatf("v%0d instr", i), instr_id, ei_exp);
      @(negedge clk);
    end
    stall = 1'b0; tb_jb = 1'b0;
    jump_target = 1'b0; jump_reg = 1'b0; jr_pc = 32'h0;

    // Branch with slot not yet granted: deferred redirect
    rst_n = 1'b0;
    lat = 3; auto_br = 1'b1; block14 = 1'b1;
    @(negedge clk);
    glog.delete(); ilog.delete();
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(instr_valid && pc_id == 32'h10) && n < 100);
    chk("pend seen 0x10", {31'h0, instr_valid}, 32'h1);
    chk("pend req", {31'h0, imem.req}, 32'h1);
    chk("pend addr", imem.addr, 32'h14);
    chk("pend gnt", {31'h0, imem.gnt}, 32'h0);
    n = 0;
    while (ilog.size() < 7 && n < 100) begin
      @(negedge clk); n++;
    end
    eg = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h24};
    ei = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h24};
    chk("pend glog size", (glog.size() >= 7) ? 32'h1 : 32'h0, 32'h1);
    chk("pend ilog size", (ilog.size() >= 7) ? 32'h1 : 32'h0, 32'h1);
    for (int i = 0; i < 7; i++) begin
      if (i < glog.size())
        chk($sformatf("pend grant%0d", i), glog[i], eg[i]);
      if (i < ilog.size())
        chk($sformatf("pend ifid%0d", i), ilog[i], ei[i]);
    end
    auto_br = 1'b0; block14 = 1'b0;

    // Reset while a request is in flight
    rst_n = 1'b0;
    @(negedge clk);
    glog.delete(); ilog.delete();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("pre-rst valid", {31'h0, instr_valid}, 32'h1);
    chk("pre-rst pc", pc_id, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid-rst req", {31'h0, imem.req}, 32'h0);
    chk("mid-rst valid", {31'h0, instr_valid}, 32'h0);
    chk("mid-rst instr", instr_id, 32'h0);
    chk("mid-rst pc", pc_id, 32'h0);
    @(negedge clk);
    glog.delete(); ilog.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (ilog.size() < 2 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("post-rst ilog", (ilog.size() >= 2) ? 32'h1 : 32'h0, 32'h1);
    if (glog.size() >= 2) begin
      chk("post-rst grant0", glog[0], 32'h0);
      chk("post-rst grant1", glog[1], 32'h4);
    end else begin
      chk("post-rst grants", glog.size(), 32'h2);
    end
    if (ilog.size() >= 2) begin
      chk("post-rst ifid0", ilog[0], 32'h0);
      chk("post-rst ifid1", ilog[1], 32'h4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
